dma_rd_streamer: RTL and testbench
==================================

Name: dma_rd_streamer

Overview:
- Descriptor-to-burst splitter that feeds the AXI master interface's read request port.
- Accepts one transfer descriptor (start address, byte count, mode) from the DMA FSM.
- Slices it into legal AXI4 read bursts and issues them one at a time over a valid/ready request channel.
- Ends each transfer with a done pulse; a misaligned descriptor ends with an error pulse instead.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, AXI data width in bits; BPB = DATA_WIDTH/8 bytes per beat.
- BYTES_WIDTH, 32, width of the descriptor byte count.
- MAX_BEATS, 256, maximum INCR burst length; legal range 1..256.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (reset rst, synchronous, active-high; clock clk)
- desc_go_i  in  1  start pulse; sampled only in IDLE
- desc_addr_i  in  ADDR_WIDTH  transfer start address
- desc_bytes_i  in  BYTES_WIDTH  transfer length in bytes
- desc_mode_i  in  1  0=INCR, 1=FIXED
- abort_i  in  1  abort current transfer
- req_valid_o  out  1  burst request valid
- req_ready_i  in  1  burst request accepted
- req_addr_o  out  ADDR_WIDTH  burst start address
- req_alen_o  out  8  beats minus 1
- req_size_o  out  3  log2(BPB)
- req_strb_o  out  BPB  byte mask of the last beat of this burst
- req_mode_o  out  1  copy of the latched desc_mode_i
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle completion pulse
- cfg_err_o  out  1  one-cycle misalignment error pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address and remaining-beat counters cleared.
- States: IDLE, CALC, REQ, DONE.
- IDLE:
  - On desc_go_i, latch addr, bytes and mode.
  - If addr[log2(BPB)-1:0] != 0: pulse cfg_err_o next cycle and stay in IDLE; no requests.
  - Else if bytes == 0: go to DONE.
  - Else go to CALC with rem_beats = ceil(bytes/BPB) and tail = bytes mod BPB.
- CALC (1 cycle): compute burst beats.
  - INCR: min(rem_beats, MAX_BEATS, (4096 - addr[11:0])/BPB).
  - FIXED: min(rem_beats, 16).
  - Register the request fields, then go to REQ.
- Latency: desc_go_i in cycle N gives req_valid_o high in cycle N+2.
- REQ:
  - req_valid_o is high; addr, alen, size, strb and mode are held stable until req_valid_o && req_ready_i. Valid never drops without a handshake.
  - On handshake: rem_beats -= beats.
  - Address update: INCR adds beats*BPB; FIXED keeps the start address.
  - If rem_beats reaches 0, go to DONE; else go to CALC.
- req_strb_o:
  - All ones, except on the final burst when tail != 0.
  - In that case it is (1<<tail)-1, with the LSB equal to the lowest byte lane.
- DONE: pulse done_o for 1 cycle, then go to IDLE. busy_o is low in that IDLE cycle.
- Abort:
  - abort_i in CALC: go to DONE with no further request.
  - abort_i in REQ: the pending request completes its handshake, then go to DONE.
  - abort_i in IDLE or DONE: ignored.
  - abort_i together with desc_go_i in IDLE: go_i wins.
- desc_go_i while busy: ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- A mid-transfer rst returns the block to IDLE immediately, with req_valid_o low the cycle after rst is sampled.

Test Plan:
- INCR, addr 0x1000, 1024 bytes, ready tied high:
  - one request: addr 0x1000, alen 255, size 2, strb 0xF;
  - done_o pulses 2 cycles after the handshake.
- 4KB crossing, INCR, addr 0x0FF0, 64 bytes:
  - request 1: addr 0x0FF0, alen 3;
  - request 2: addr 0x1000, alen 11;
  - no burst crosses 0x1000.
- FIXED, addr 0x2000, 100 bytes:
  - request 1: addr 0x2000, alen 15, mode 1;
  - request 2: addr 0x2000, alen 8, strb 0xF.
- Partial tail, INCR, addr 0x3000, 10 bytes: one request, alen 2, strb 0x3.
- Backpressure and abort:
  - hold req_ready_i low for 5 cycles: all req_* outputs stay stable;
  - assert abort_i during the stall: after the handshake there are no further requests, done_o pulses, busy_o drops.
- Error and empty cases:
  - addr 0x4002: cfg_err_o pulses, no requests;
  - 0 bytes at 0x5000: done_o pulses, no requests;
  - rst mid-REQ: all outputs 0.

Source files
------------

// File: rtl/dma_rd_streamer.sv
// Splits one DMA read descriptor into legal AXI4 read bursts (INCR: 4KB/MAX_BEATS-bounded, FIXED: <=16 beats).
// Latency: go -> first req_valid_o in 2 cycles; req_* held stable while req_ready_i is low, done_o 2 cycles after last handshake.
module dma_rd_streamer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BYTES_WIDTH = 32,
  parameter int MAX_BEATS   = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    desc_go_i,
  input  logic [ADDR_WIDTH-1:0]   desc_addr_i,
  input  logic [BYTES_WIDTH-1:0]  desc_bytes_i,
  input  logic                    desc_mode_i,
  input  logic                    abort_i,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic [ADDR_WIDTH-1:0]   req_addr_o,
  output logic [7:0]              req_alen_o,
  output logic [2:0]              req_size_o,
  output logic [DATA_WIDTH/8-1:0] req_strb_o,
  output logic                    req_mode_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    cfg_err_o
);

  localparam int BPB     = DATA_WIDTH / 8;
  localparam int LOG_BPB = $clog2(BPB);
  localparam int TW      = (LOG_BPB > 0) ? LOG_BPB : 1;
  localparam int RW      = BYTES_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, CALC, REQ, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [RW-1:0]         rem_q;
  logic [TW-1:0]         tail_q;
  logic                  mode_q;
  logic                  abort_q;
  logic [8:0]            beats_q;

  logic                  misaligned;
  logic [RW-1:0]         go_beats;
  logic [TW-1:0]         go_tail;
  logic [12:0]           page_beats;
  logic [12:0]           lim;
  logic [8:0]            calc_beats;
  logic                  calc_last;
  logic [BPB-1:0]        tail_mask;

  assign misaligned = (desc_addr_i & ADDR_WIDTH'(BPB - 1)) != '0;
  assign go_beats   = (RW'(desc_bytes_i) + RW'(BPB - 1)) >> LOG_BPB;
  assign go_tail    = TW'(desc_bytes_i & BYTES_WIDTH'(BPB - 1));

  // Beats left before the next 4KB page boundary; address is beat-aligned so this is >= 1.
  assign page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> LOG_BPB;
  assign lim        = mode_q ? 13'd16
                    : ((page_beats < 13'(MAX_BEATS)) ? page_beats : 13'(MAX_BEATS));
  assign calc_beats = (rem_q < RW'(lim)) ? rem_q[8:0] : lim[8:0];
  assign calc_last  = (rem_q == RW'(calc_beats));
  assign tail_mask  = (BPB'(1) << tail_q) - BPB'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      tail_q      <= '0;
      mode_q      <= 1'b0;
      abort_q     <= 1'b0;
      beats_q     <= '0;
      req_valid_o <= 1'b0;
      req_addr_o  <= '0;
      req_alen_o  <= '0;
      req_size_o  <= '0;
      req_strb_o  <= '0;
      req_mode_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cfg_err_o   <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      cfg_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (desc_go_i) begin
            addr_q  <= desc_addr_i;
            mode_q  <= desc_mode_i;
            tail_q  <= go_tail;
            rem_q   <= go_beats;
            abort_q <= 1'b0;
            if (misaligned) begin
              cfg_err_o <= 1'b1;
            end else if (desc_bytes_i == '0) begin
              state  <= DONE;
              busy_o <= 1'b1;
            end else begin
              state  <= CALC;
              busy_o <= 1'b1;
            end
          end
        end
        CALC: begin
          if (abort_i) begin
            state <= DONE;
          end else begin
            req_addr_o  <= addr_q;
            req_alen_o  <= 8'(calc_beats - 9'd1);
            req_size_o  <= 3'(LOG_BPB);
            req_strb_o  <= (calc_last && tail_q != '0) ? tail_mask : '1;
            req_mode_o  <= mode_q;
            beats_q     <= calc_beats;
            req_valid_o <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          // An abort seen during a stall is remembered until the pending handshake completes.
          if (abort_i) abort_q <= 1'b1;
          if (req_ready_i) begin
            req_valid_o <= 1'b0;
            rem_q       <= rem_q - RW'(beats_q);
            if (!mode_q) addr_q <= addr_q + (ADDR_WIDTH'(beats_q) << LOG_BPB);
            state <= (rem_q == RW'(beats_q) || abort_q || abort_i) ? DONE : CALC;
          end
        end
        DONE: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          abort_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_rd_streamer.sv
// Directed bench for dma_rd_streamer: inputs driven and outputs checked on the falling clock edge.
module tb_dma_rd_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        desc_go;
  logic [31:0] desc_addr;
  logic [31:0] desc_bytes;
  logic        desc_mode;
  logic        abort;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_alen;
  logic [2:0]  req_size;
  logic [3:0]  req_strb;
  logic        req_mode;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int pass_cnt = 0;
  int total    = 0;
  int req_cnt  = 0;
  int base;

  dma_rd_streamer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTES_WIDTH(32), .MAX_BEATS(256)
  ) dut (
    .clk(clk), .rst(rst),
    .desc_go_i(desc_go), .desc_addr_i(desc_addr), .desc_bytes_i(desc_bytes),
    .desc_mode_i(desc_mode), .abort_i(abort),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .req_addr_o(req_addr),
    .req_alen_o(req_alen), .req_size_o(req_size), .req_strb_o(req_strb),
    .req_mode_o(req_mode), .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (req_valid && req_ready) req_cnt <= req_cnt + 1;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] a, input logic [7:0] alen,
                         input logic [3:0] strb, input logic m);
    chk({tag, "_valid"}, 64'(req_valid), 64'd1);
    chk({tag, "_addr"},  64'(req_addr),  64'(a));
    chk({tag, "_alen"},  64'(req_alen),  64'(alen));
    chk({tag, "_size"},  64'(req_size),  64'd2);
    chk({tag, "_strb"},  64'(req_strb),  64'(strb));
    chk({tag, "_mode"},  64'(req_mode),  64'(m));
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic m);
    desc_addr  = a;
    desc_bytes = b;
    desc_mode  = m;
    desc_go    = 1'b1;
    tick();
    desc_go    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; desc_go = 1'b0; desc_addr = '0; desc_bytes = '0; desc_mode = 1'b0;
    abort = 1'b0; req_ready = 1'b0;
    tick(2);
    chk("reset_outs", 64'({req_valid, req_addr, req_alen, req_size, req_strb, req_mode,
                           busy, done, cfg_err}), 64'd0);
    rst = 1'b0; req_ready = 1'b1;
    tick();

    // Single 256-beat INCR burst, exact latency checks
    base = req_cnt;
    start(32'h1000, 32'd1024, 1'b0);
    chk("incr1k_calc_busy", 64'(busy), 64'd1);
    chk("incr1k_calc_valid", 64'(req_valid), 64'd0);
    tick();
    chk_req("incr1k", 32'h1000, 8'd255, 4'hF, 1'b0);
    tick();
    chk("incr1k_post_valid", 64'(req_valid), 64'd0);
    chk("incr1k_post_done", 64'(done), 64'd0);
    tick();
    chk("incr1k_done", 64'(done), 64'd1);
    chk("incr1k_idle_busy", 64'(busy), 64'd0);
    tick();
    chk("incr1k_done_pulse", 64'(done), 64'd0);
    chk("incr1k_nreq", 64'(req_cnt - base), 64'd1);

    // 4KB crossing
    base = req_cnt;
    start(32'h0FF0, 32'd64, 1'b0);
    tick();
    chk_req("cross_b1", 32'h0FF0, 8'd3, 4'hF, 1'b0);
    tick();
    chk("cross_gap_valid", 64'(req_valid), 64'd0);
    tick();
    chk_req("cross_b2", 32'h1000, 8'd11, 4'hF, 1'b0);
    tick(2);
    chk("cross_done", 64'(done), 64'd1);
    chk("cross_nreq", 64'(req_cnt - base), 64'd2);

    // FIXED mode, 25 beats -> 16 + 9
    base = req_cnt;
    start(32'h2000, 32'd100, 1'b1);
    tick();
    chk_req("fixed_b1", 32'h2000, 8'd15, 4'hF, 1'b1);
    tick(2);
    chk_req("fixed_b2", 32'h2000, 8'd8, 4'hF, 1'b1);
    tick(2);
    chk("fixed_done", 64'(done), 64'd1);
    chk("fixed_nreq", 64'(req_cnt - base), 64'd2);

    // Partial tail
    base = req_cnt;
    start(32'h3000, 32'd10, 1'b0);
    tick();
    chk_req("tail", 32'h3000, 8'd2, 4'h3, 1'b0);
    tick(2);
    chk("tail_done", 64'(done), 64'd1);
    chk("tail_nreq", 64'(req_cnt - base), 64'd1);

    // Backpressure with abort during the stall; without abort a second burst at 0x7000 would follow
    req_ready = 1'b0;
    base = req_cnt;
    start(32'h6FF8, 32'd40, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_req("stall", 32'h6FF8, 8'd1, 4'hF, 1'b0);
      abort = (k == 1);
      tick();
    end
    req_ready = 1'b1;
    tick();
    chk("abort_post_valid", 64'(req_valid), 64'd0);
    chk("abort_post_busy", 64'(busy), 64'd1);
    tick();
    chk("abort_done", 64'(done), 64'd1);
    chk("abort_busy_low", 64'(busy), 64'd0);
    tick(3);
    chk("abort_nreq", 64'(req_cnt - base), 64'd1);
    chk("abort_quiet", 64'(req_valid), 64'd0);

    // Abort while in CALC: no request at all
    base = req_cnt;
    start(32'h8000, 32'd64, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("calc_abort_valid", 64'(req_valid), 64'd0);
    chk("calc_abort_busy", 64'(busy), 64'd1);
    tick();
    chk("calc_abort_done", 64'(done), 64'd1);
    chk("calc_abort_nreq", 64'(req_cnt - base), 64'd0);

    // go and abort together in IDLE: go wins
    abort = 1'b1;
    start(32'h9000, 32'd8, 1'b0);
    abort = 1'b0;
    tick();
    chk_req("go_wins", 32'h9000, 8'd1, 4'hF, 1'b0);
    tick(2);
    chk("go_wins_done", 64'(done), 64'd1);

    // Misaligned descriptor
    base = req_cnt;
    start(32'h4002, 32'd16, 1'b0);
    chk("err_pulse", 64'(cfg_err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    tick();
    chk("err_pulse_end", 64'(cfg_err), 64'd0);
    tick(3);
    chk("err_nreq", 64'(req_cnt - base), 64'd0);
    chk("err_valid", 64'(req_valid), 64'd0);

    // Zero-length descriptor
    base = req_cnt;
    start(32'h5000, 32'd0, 1'b0);
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_done_early", 64'(done), 64'd0);
    tick();
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_idle_busy", 64'(busy), 64'd0);
    chk("zero_nreq", 64'(req_cnt - base), 64'd0);

    // Reset while a request is pending
    req_ready = 1'b0;
    start(32'h7000, 32'd64, 1'b0);
    tick();
    chk("rst_pre_valid", 64'(req_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_outs", 64'({req_valid, req_addr, req_alen, req_size, req_strb, req_mode,
                             busy, done, cfg_err}), 64'd0);
    rst = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
